// File: rtl/mips_pkg.sv
// Shared opcode, funct and ALU-control definitions
// for the single-cycle MIPS subset.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_e;

endpackage

// File: rtl/mips_if.sv
// Core <-> memory bus: instruction fetch
// and data memory access.
interface mips_if;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        memwrite;

  modport master (
    output pc, dataadr, writedata, memwrite,
    input  instr, readdata
  );

  modport slave (
    input  pc, dataadr, writedata, memwrite,
    output instr, readdata
  );
endinterface

// File: rtl/mips_core.sv
// Single-cycle MIPS core: PC, decoder,
// register file and ALU.
module mips_core
  import mips_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  mips_if.master bus
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] pc_next;
  logic [31:0] rf [32];

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  wa;
  logic [31:0] imm_se;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] srcb;
  logic [31:0] result;
  logic [31:0] wd;
  logic        zero;

  logic        reg_we;
  logic        mem_we;
  logic        alu_imm;
  logic        from_mem;
  logic        dst_rd;
  logic        is_beq;
  logic        is_j;
  alu_op_e     alu_ctl;

  assign op     = bus.instr[31:26];
  assign rs     = bus.instr[25:21];
  assign rt     = bus.instr[20:16];
  assign rd     = bus.instr[15:11];
  assign funct  = bus.instr[5:0];
  assign imm_se = {{16{bus.instr[15]}},
                   bus.instr[15:0]};

  assign a = (rs == 5'd0) ? '0 : rf[rs];
  assign b = (rt == 5'd0) ? '0 : rf[rt];

  always_comb begin
    reg_we   = 1'b0;
    mem_we   = 1'b0;
    alu_imm  = 1'b0;
    from_mem = 1'b0;
    dst_rd   = 1'b0;
    is_beq   = 1'b0;
    is_j     = 1'b0;
    alu_ctl  = ALU_ADD;
    unique case (1'b1)
      (op == OP_RTYPE): begin
        dst_rd = 1'b1;
        reg_we = 1'b1;
        unique case (funct)
          F_ADD:   alu_ctl = ALU_ADD;
          F_SUB:   alu_ctl = ALU_SUB;
          F_AND:   alu_ctl = ALU_AND;
          F_OR:    alu_ctl = ALU_OR;
          F_SLT:   alu_ctl = ALU_SLT;
          default: reg_we  = 1'b0;
        endcase
      end
      (op == OP_LW): begin
        reg_we   = 1'b1;
        alu_imm  = 1'b1;
        from_mem = 1'b1;
      end
      (op == OP_SW): begin
        mem_we  = 1'b1;
        alu_imm = 1'b1;
      end
      (op == OP_BEQ): begin
        is_beq  = 1'b1;
        alu_ctl = ALU_SUB;
      end
      (op == OP_ADDI): begin
        reg_we  = 1'b1;
        alu_imm = 1'b1;
      end
      (op == OP_J): is_j = 1'b1;
      default: ;
    endcase
  end

  assign srcb = alu_imm ? imm_se : b;

  always_comb begin
    unique case (alu_ctl)
      ALU_ADD: result = a + srcb;
      ALU_SUB: result = a - srcb;
      ALU_AND: result = a & srcb;
      ALU_OR:  result = a | srcb;
      ALU_SLT: result = {31'd0,
        $signed(a) < $signed(srcb)};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);
  assign wa   = dst_rd ? rd : rt;
  assign wd   = from_mem ? bus.readdata : result;

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    pc_next = pc_plus4;
    if (is_beq && zero)
      pc_next = pc_plus4 +
        {imm_se[29:0], 2'b00};
    else if (is_j)
      pc_next = {pc_plus4[31:28],
        bus.instr[25:0], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (reset) pc <= '0;
    else       pc <= pc_next;
  end

  // $0 stays hardwired: writes to it are dropped
  always_ff @(posedge clk) begin
    if (!reset && reg_we && wa != 5'd0)
      rf[wa] <= wd;
  end

  assign bus.pc        = pc;
  assign bus.dataadr   = result;
  assign bus.writedata = b;
  assign bus.memwrite  = mem_we & ~reset;

endmodule

// File: rtl/top.sv
// Single-cycle MIPS system: core plus
// word-addressed instruction and data memories.
module top
  import mips_pkg::*;
#(
  parameter string IMEM_FILE = "memfile.dat",
  parameter int    MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] writedata,
  output logic [31:0] dataadr,
  output logic        memwrite
);

  localparam int AW = $clog2(MEM_WORDS);

  logic [31:0] imem [MEM_WORDS];
  logic [31:0] dmem [MEM_WORDS];
  logic        unused_bits;

  mips_if bus ();

  mips_core u_core (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.instr    = imem[bus.pc[AW+1:2]];
  assign bus.readdata = dmem[bus.dataadr[AW+1:2]];

  always_ff @(posedge clk) begin
    if (bus.memwrite)
      dmem[bus.dataadr[AW+1:2]] <= bus.writedata;
  end

  assign writedata = bus.writedata;
  assign dataadr   = bus.dataadr;
  assign memwrite  = bus.memwrite;

  assign unused_bits = ^{bus.pc[31:AW+2],
    bus.pc[1:0], bus.dataadr[31:AW+2],
    bus.dataadr[1:0]};

endmodule

// File: tb/tb_top.sv
// Scoreboard bench: ISA-level interpreter predicts
// per-cycle PC and stores; a negedge monitor checks.
module tb_top;
  localparam int W = 64;

  typedef struct packed {
    logic [31:0] pc;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wd;
  } rec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] writedata;
  logic [31:0] dataadr;
  logic        memwrite;

  int tests = 0;
  int fails = 0;

  rec_t        exp_q [$];
  logic [31:0] act_pc [$];
  logic [63:0] act_st [$];
  rec_t        e;

  logic [31:0] prog [W];
  logic [31:0] mr [32];
  logic [31:0] mm [W];

  top #(.IMEM_FILE(""), .MEM_WORDS(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .writedata (writedata),
    .dataadr   (dataadr),
    .memwrite  (memwrite)
  );

  mips_if tap ();
  assign tap.pc        = dut.u_core.pc;
  assign tap.instr     = dut.bus.instr;
  assign tap.dataadr   = dataadr;
  assign tap.writedata = writedata;
  assign tap.readdata  = dut.bus.readdata;
  assign tap.memwrite  = memwrite;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset) begin
      tests++;
      if (tap.memwrite !== 1'b0) begin
        fails++;
        $display("FAIL reset_memwrite got %b want 0",
          tap.memwrite);
      end
    end else if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL extra_cycle pc got %h want none",
        tap.pc);
    end else begin
      e = exp_q.pop_front();
      act_pc.push_back(tap.pc);
      if (tap.memwrite)
        act_st.push_back({tap.dataadr, tap.writedata});
      tests++;
      if (tap.pc !== e.pc) begin
        fails++;
        $display("FAIL pc got %h want %h", tap.pc, e.pc);
      end
      tests++;
      if (tap.memwrite !== e.we) begin
        fails++;
        $display("FAIL memwrite pc=%h got %b want %b",
          e.pc, tap.memwrite, e.we);
      end
      if (e.we) begin
        tests++;
        if (tap.dataadr !== e.adr ||
            tap.writedata !== e.wd) begin
          fails++;
          $display("FAIL store pc=%h got %h/%h want %h/%h",
            e.pc, tap.dataadr, tap.writedata, e.adr, e.wd);
        end
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  task automatic wr(input logic [4:0] r,
                    input logic [31:0] v);
    if (r != 5'd0) mr[r] = v;
  endtask

  // ISA interpreter: runs n instructions from address 0
  task automatic model_run(input int n);
    logic [31:0] pc, ins, a, b, nxt, adr, se;
    logic signed [15:0] imm;
    int unsigned idx;
    rec_t r;
    pc = 0;
    for (int k = 0; k < n; k++) begin
      idx = (pc / 4) % W;
      ins = prog[idx];
      a = mr[ins[25:21]];
      b = mr[ins[20:16]];
      imm = ins[15:0];
      se = 32'(imm);
      nxt = pc + 4;
      adr = a + se;
      r = '{pc: pc, we: 1'b0, adr: '0, wd: '0};
      case (ins[31:26])
        6'h00: case (ins[5:0])
          6'h20: wr(ins[15:11], a + b);
          6'h22: wr(ins[15:11], a - b);
          6'h24: wr(ins[15:11], a & b);
          6'h25: wr(ins[15:11], a | b);
          6'h2A: wr(ins[15:11],
            ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
          default: ;
        endcase
        6'h23: wr(ins[20:16], mm[(adr / 4) % W]);
        6'h2B: begin
          r.we = 1'b1;
          r.adr = adr;
          r.wd = b;
          mm[(adr / 4) % W] = b;
        end
        6'h04: if (a == b) nxt = pc + 4 + se * 4;
        6'h08: wr(ins[20:16], adr);
        6'h02: nxt = {nxt[31:28], ins[25:0], 2'b00};
        default: ;
      endcase
      exp_q.push_back(r);
      pc = nxt;
    end
  endtask

  task automatic load_prog;
    for (int i = 0; i < W; i++) dut.imem[i] = prog[i];
  endtask

  task automatic dut_run(input int n);
    act_pc.delete();
    act_st.delete();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (n) @(posedge clk);
    #1 reset = 1'b1;
    chk("leftover_expect", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run(input int n);
    model_run(n);
    dut_run(n);
  endtask

  function automatic logic [31:0] itype(
    input logic [5:0] op, input logic [4:0] rs,
    input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rtype(
    input logic [4:0] rs, input logic [4:0] rt,
    input logic [4:0] rd, input logic [5:0] f);
    return {6'h00, rs, rt, rd, 5'd0, f};
  endfunction

  function automatic logic [31:0] rand_ins;
    logic [4:0] rs, rt, rd;
    logic [5:0] fs [6];
    fs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h21};
    rs = 5'($urandom_range(0, 7));
    rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 9))
      0, 1: return itype(6'h08, rs, rt, 16'($urandom));
      2, 3: return rtype(rs, rt, rd,
              fs[$urandom_range(0, 5)]);
      4: return itype(6'h2B, 5'd0, rt,
              16'($urandom_range(0, 255)));
      5: return itype(6'h23, 5'd0, rt,
              16'($urandom_range(0, 255)));
      6: return itype(6'h04, rs, rt,
              16'($signed($urandom_range(0, 8)) - 4));
      7: return {6'h02, 26'($urandom_range(0, W - 1))};
      8: return $urandom;
      default: return itype(6'h2B, rs, rt, 16'($urandom));
    endcase
  endfunction

  logic [31:0] mf [18] = '{
    32'h20020005, 32'h2003000c, 32'h2067fff7,
    32'h00e22025, 32'h00642824, 32'h00a42820,
    32'h10a7000a, 32'h0064202a, 32'h10800001,
    32'h20050000, 32'h00e2202a, 32'h00853820,
    32'h00e23822, 32'hac670044, 32'h8c020050,
    32'h08000011, 32'h20020001, 32'hac020054};

  logic [31:0] p2 [22] = '{
    32'h20020005, 32'hac020000, 32'h20030005,
    32'h10430001, 32'hac020004, 32'h2004ffff,
    32'h10440001, 32'h08000010, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h20050001, 32'h0085302a,
    32'hac060008, 32'h00430020, 32'hac00000c,
    32'hac040010};

  task automatic check_memfile;
    logic ok;
    chk("mf_first_adr", act_st.size() > 0 ?
      64'(act_st[0][63:32]) : 64'hdead, 64'd80);
    ok = 1'b1;
    foreach (act_st[i])
      if (act_st[i][63:32] != 80 &&
          act_st[i][63:32] != 84) ok = 1'b0;
    chk("mf_store_addrs", 64'(ok), 64'd1);
    chk("mf_final_store", act_st.size() > 0 ?
      act_st[act_st.size() - 1] : 64'hdead,
      {32'd84, 32'd7});
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mr[i] = '0;
    for (int i = 0; i < W; i++) mm[i] = '0;

    // clear registers and data memory
    for (int i = 0; i < W; i++) prog[i] = '0;
    for (int k = 1; k < 32; k++)
      prog[k - 1] = itype(6'h08, 5'd0, 5'(k), 16'd0);
    prog[31] = 32'h20010100;
    prog[32] = 32'h2021fffc;
    prog[33] = 32'hac200000;
    prog[34] = 32'h10200001;
    prog[35] = 32'h08000020;
    load_prog();
    run(300);

    // standard program
    for (int i = 0; i < W; i++) prog[i] = i < 18 ? mf[i] : '0;
    load_prog();
    run(16);
    check_memfile();

    // reset while a sw is current, then rerun
    run(12);
    run(16);
    chk("rst_pc0", act_pc.size() > 0 ?
      64'(act_pc[0]) : 64'hdead, 64'd0);
    check_memfile();

    // directed: sw, beq both ways, j, slt, $0
    for (int i = 0; i < W; i++) prog[i] = i < 22 ? p2[i] : '0;
    load_prog();
    run(13);
    chk("p2_nstores", 64'(act_st.size()), 64'd4);
    if (act_st.size() == 4) begin
      chk("p2_sw_addi", act_st[0], {32'd0, 32'd5});
      chk("p2_slt", act_st[1], {32'd8, 32'd1});
      chk("p2_zero_reg", act_st[2], {32'd12, 32'd0});
      chk("p2_neg1", act_st[3], {32'd16, 32'hffffffff});
    end
    if (act_pc.size() == 13) begin
      chk("beq_taken", 64'(act_pc[4]), 64'h14);
      chk("beq_fall", 64'(act_pc[6]), 64'h1c);
      chk("j_target", 64'(act_pc[7]), 64'h40);
    end else begin
      chk("p2_trace_len", 64'(act_pc.size()), 64'd13);
    end

    // random programs
    for (int t = 0; t < 6; t++) begin
      for (int k = 1; k < 8; k++)
        prog[k - 1] = itype(6'h08, 5'd0, 5'(k), 16'($urandom));
      for (int i = 7; i < W; i++) prog[i] = rand_ins();
      load_prog();
      run(80);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
